// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : mem_stage_ctrl                                                |
// | Description : Memory-stage load/store sequencer: converts a memory-stage    |
// |               access into one req/ack bus transaction, stalls MEM/WB until  |
// |               it completes and reports misalignment/access-fault causes.    |
// |               Optional REQ watchdog enabled by defining MEM_TIMEOUT_EN.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module mem_stage_ctrl #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_mem_access,
    input  logic                  i_mem_we,
    input  logic [1:0]            i_size,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_flush,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic                  i_mem_err,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_stall_wb,
    output logic [DATA_WIDTH-1:0] o_read_data,
    output logic                  o_fault,
    output logic [3:0]            o_cause
);

    localparam logic [3:0] C_CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] C_CAUSE_LD_ACCESS   = 4'd5;
    localparam logic [3:0] C_CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] C_CAUSE_ST_ACCESS   = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("mem_stage_ctrl: TIMEOUT_CYCLES must be in 1..255");
        end
    endgenerate

    state_t                  state_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [DATA_WIDTH-1:0]   read_data_q;
    logic                    fault_q;
    logic [3:0]              cause_q;
    logic                    drop_q;

    logic                    w_misaligned;
    logic                    w_drop;
    logic                    w_timeout;

    always_comb begin
        w_misaligned = 1'b0;
        case (i_size)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = i_addr[0];
            2'd2:    w_misaligned = |i_addr[1:0];
            default: w_misaligned = |i_addr[2:0];
        endcase
    end

    // A flush arriving in the ack cycle itself also kills the access.
    assign w_drop = drop_q | i_flush;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt_q;
    assign w_timeout = (tmo_cnt_q == C_TMO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            read_data_q <= '0;
            fault_q     <= 1'b0;
            cause_q     <= 4'd0;
            drop_q      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q   <= 8'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_mem_access && !i_flush) begin
                        if (w_misaligned) begin
                            fault_q <= 1'b1;
                            cause_q <= i_mem_we ? C_CAUSE_ST_MISALIGN : C_CAUSE_LD_MISALIGN;
                            state_q <= ST_RESP;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= i_mem_we;
                            mem_addr_q  <= i_addr;
                            mem_wdata_q <= i_wdata;
                            drop_q      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                            tmo_cnt_q   <= 8'd0;
`endif
                            state_q     <= ST_REQ;
                        end
                    end
                end

                ST_REQ: begin
                    if (i_flush) begin
                        drop_q <= 1'b1;
                    end
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (i_mem_ack) begin
                        mem_req_q <= 1'b0;
                        drop_q    <= 1'b0;
                        if (w_drop) begin
                            state_q <= ST_IDLE;
                        end else begin
                            if (!mem_we_q) begin
                                read_data_q <= i_mem_rdata;
                            end
                            if (i_mem_err) begin
                                fault_q <= 1'b1;
                                cause_q <= mem_we_q ? C_CAUSE_ST_ACCESS : C_CAUSE_LD_ACCESS;
                            end
                            state_q <= ST_RESP;
                        end
                    end else if (w_timeout) begin
                        mem_req_q <= 1'b0;
                        drop_q    <= 1'b0;
                        if (w_drop) begin
                            state_q <= ST_IDLE;
                        end else begin
                            fault_q <= 1'b1;
                            cause_q <= mem_we_q ? C_CAUSE_ST_ACCESS : C_CAUSE_LD_ACCESS;
                            state_q <= ST_RESP;
                        end
                    end else begin
`ifdef MEM_TIMEOUT_EN
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
`endif
                    end
                end

                ST_RESP: begin
                    fault_q <= 1'b0;
                    cause_q <= 4'd0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Gated by reset so every output reads 0 while reset is held.
    assign o_stall_wb  = i_arst_n &
                         (((state_q == ST_IDLE) & i_mem_access & ~i_flush) |
                          (state_q == ST_REQ));
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_read_data = read_data_q;
    assign o_fault     = fault_q;
    assign o_cause     = cause_q;

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage access sequencer sitting between the execute/memory pipeline register and the data memory port. It turns a load/store that arrives in the memory stage into a req/ack bus transaction and stalls the MEM/WB pipeline register until the access completes. It also reports misalignment and access faults as cause codes to the trap logic. One access is handled at a time.

## Interface
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, data width.
- TIMEOUT_CYCLES, 255, cycles in REQ before a watchdog fault; used only with MEM_TIMEOUT_EN; range 1..255.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_arst_n  input  1  reset, asynchronous, active-low.
- i_mem_access  input  1  a load/store is present in the memory stage.
- i_mem_we  input  1  1 = store, 0 = load.
- i_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- i_addr  input  ADDR_WIDTH  byte address.
- i_wdata  input  DATA_WIDTH  store data.
- i_flush  input  1  kill the memory-stage instruction.
- o_mem_req  output  1  bus request.
- o_mem_we  output  1  bus write enable.
- o_mem_addr  output  ADDR_WIDTH  bus address.
- o_mem_wdata  output  DATA_WIDTH  bus write data.
- i_mem_ack  input  1  bus completes the current request.
- i_mem_err  input  1  bus error; valid only with i_mem_ack.
- i_mem_rdata  input  DATA_WIDTH  bus read data; valid with i_mem_ack.
- o_stall_wb  output  1  hold the MEM/WB register and the upstream stages.
- o_read_data  output  DATA_WIDTH  captured load data.
- o_fault  output  1  the completing access faulted.
- o_cause  output  4  fault cause: 4 = load misaligned, 5 = load access fault, 6 = store misaligned, 7 = store access fault; 0 when no fault.

## Operation
- States: IDLE, REQ, RESP. On reset: IDLE, and every output is 0.
- Misaligned access: the address is not a multiple of 2^i_size.
- IDLE:
  - If i_mem_access=1, i_flush=0 and the address is aligned: latch we/addr/wdata into the bus registers and go to REQ.
  - If the address is misaligned: issue no request, go to RESP with o_fault=1 and cause 4 (load) or 6 (store).
  - If i_flush=1: stay in IDLE.
- REQ:
  - o_mem_req=1; bus outputs stay stable until ack.
  - On i_mem_ack, capture i_mem_rdata into o_read_data for loads only; stores leave it unchanged.
  - On i_mem_ack with i_mem_err=1: o_fault=1, cause 5 or 7.
  - After the ack, go to RESP.
- RESP:
  - Lasts one cycle; o_fault/o_cause are valid during this cycle; then go to IDLE unconditionally.
  - RESP never starts a new access, even if i_mem_access is still high.
  - o_fault/o_cause clear to 0 on leaving RESP.
- Flush in REQ:
  - The bus handshake is never abandoned. A drop flag is set and the block waits for ack, then returns to IDLE without RESP.
  - Load data from the dropped access is discarded, and no fault is reported.
- o_stall_wb = (IDLE and i_mem_access and not i_flush) or REQ. It is a combinational output that is low in RESP, so the pipeline advances at the end of RESP.
- o_read_data holds its value until the next load ack.

## Timing
- Zero-wait memory (ack in the first REQ cycle): stall is high in cycles 0–1 and the pipeline advances at the end of cycle 2. Three cycles per access.
- Each extra wait cycle adds one cycle.
- Misaligned access: two cycles (IDLE → RESP); o_mem_req stays 0 throughout.
- o_mem_req rises in the cycle after IDLE accepts the access. It falls in the cycle after ack.
- Back-to-back accesses: the next access starts in the IDLE cycle that follows RESP.
- Asynchronous reset mid-REQ: o_mem_req drops immediately and the state returns to IDLE. The memory side must tolerate this.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the block drops o_mem_req and goes to RESP with an access fault (5/7).
  - An ack in the same cycle the count is reached takes priority over the timeout.
  - A timeout while the drop flag is set goes to IDLE silently.
- MEM_TIMEOUT_EN undefined: no counter is built, and REQ waits indefinitely for ack.

## Test plan
- Load, aligned double, addr 0x1000, ack in 1st REQ cycle, rdata 0xDEADBEEF_CAFEF00D → o_stall_wb high for 2 cycles; o_read_data = 0xDEADBEEF_CAFEF00D in RESP; o_fault=0.
- Store, word, addr 0x2004, data 0x55, ack after 3 wait cycles → o_mem_we=1 and addr/wdata stable for all 4 REQ cycles; stall for 5 cycles; o_read_data unchanged.
- Load, half, addr 0x1001 → o_mem_req never asserted; RESP with o_fault=1, o_cause=4. Same access as a store → o_cause=6.
- Load, ack with i_mem_err=1 → o_cause=5. Store, ack with i_mem_err=1 → o_cause=7.
- i_flush pulsed in the 2nd REQ cycle, ack 2 cycles later → no RESP; o_fault=0; o_read_data not updated; next access accepted the cycle after returning to IDLE.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never given → req drops after 4 REQ cycles; RESP with cause 5 (load). i_arst_n low mid-REQ → all outputs 0 immediately.
